aes_dec_addkey_invmix: RTL
==========================

# aes_dec_addkey_invmix

Decryption-side round-key stage for the AES-256 core, the counterpart of the encryption AddRoundKey stage. It accepts one 128-bit state with its round index and fetches that round's key from the key-schedule store through a request/acknowledge handshake. It XORs the key into the state and, for middle rounds, applies InvMixColumns. It sits after the InvSubBytes stage in the decryption round loop and returns its result to the round controller over a valid/ready handshake.

## Interface
- NR, 14, number of AES-256 rounds; highest valid round index.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers in_state/in_round.
- in_ready  out  1  block can accept; high only in IDLE.
- in_state  in  128  state; byte i = bits [8*i+:8]; column c = bytes 4c..4c+3, byte 4c is row 0.
- in_round  in  4  round index 0..15.
- key_req  out  1  round-key request; held until acknowledged.
- key_idx  out  4  requested key index; equals the latched round.
- key_ack  in  1  key_data valid this cycle.
- key_data  in  128  round key, same byte order as state.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_state  out  128  result state.
- out_round  out  4  round index of the result.
- out_err  out  1  result came from an out-of-range round.

## Operation
- FSM states: IDLE, KEY, OUT.
- IDLE: in_ready=1. When in_valid is high, latch in_state and in_round and go to KEY. If in_round > NR, set err_q, skip KEY, and go to OUT with out_state = in_state unchanged.
- KEY: key_req=1, key_idx=latched round. When key_ack is high, compute t = state ^ key_data. If 1 <= round <= NR-1, out_state = InvMixColumns(t); for round 0 or NR, out_state = t. Register the result and go to OUT.
- OUT: out_valid=1. out_state, out_round and out_err stay stable until out_ready is high, then go to IDLE.
- InvMixColumns uses the standard per-column matrix {0e,0b,0d,09} with GF(2^8) reduction polynomial 0x11b.
- key_ack outside KEY is ignored.
- in_valid is ignored outside IDLE. Upstream must hold in_state and in_round stable while in_valid is high.

## Timing
- Reset values: in_ready=0 during reset and 1 after reset release (FSM in IDLE). key_req=0, key_idx=0, out_valid=0, out_state=0, out_round=0, out_err=0.
- Accept at edge T. key_req is high from T+1. If key_ack arrives in cycle T+1, out_valid rises at edge T+2, so minimum latency is 2 cycles.
- out_ready in the first out_valid cycle gives in_ready=1 in the next cycle. Minimum throughput is 1 block per 3 cycles.
- key_req falls in the cycle after key_ack. A key_ack held high for extra cycles has no further effect.
- Out-of-range round: out_valid rises at edge T+1, with no key request.
- Asserting resetn low mid-operation aborts immediately. All outputs return to reset values, and a pending key request is dropped.

## Configuration
- AES_DEC_INVMIX_EN defined: InvMixColumns is applied for rounds 1..NR-1 as above.
- AES_DEC_INVMIX_EN undefined: the stage is a pure AddRoundKey for every valid round (out_state = state ^ key). InvMixColumns is then performed by a separate downstream stage. All handshakes and latencies are unchanged.

## Structure
- Package aes_dec_pkg holds:
  - typedef state_t (logic [15:0][7:0]);
  - typedef round_t (logic [3:0]);
  - localparam NR = 14;
  - functions xtime, gmul (GF(2^8) multiply);
  - FSM state enum.
- Sub-module aes_inv_mixcolumn: combinational, 32-bit column in and out. It is instantiated 4 times, only under AES_DEC_INVMIX_EN.

## Test plan
- Round 5, every column = 8e,4d,a1,bc, key all 00, key_ack 1 cycle after key_req -> out_state every column = db,13,53,45; out_round=5; out_valid at accept+2.
- Round 0, state all 00, key all ff -> out_state all ff, no InvMix. Round 14, state == key -> out_state all 00.
- Round 15 -> no key_req ever raised; out_err=1; out_state == in_state; out_valid at accept+1.
- key_ack delayed 4 cycles, out_ready held low 3 cycles -> key_req held 5 cycles; out_state stable; in_ready low throughout; in_ready=1 the cycle after out_ready.
- Reset pulsed while in KEY -> key_req=0 and out_valid=0 immediately. A later key_ack is ignored, and the next transaction completes correctly.
- AES_DEC_INVMIX_EN undefined, round 5 with the first scenario's vector -> out_state every column = 8e,4d,a1,bc.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-256 decryption datapath.
package aes_dec_pkg;

  typedef logic [15:0][7:0] state_t;
  typedef logic [3:0]       round_t;

  // Number of AES-256 rounds; also the highest valid round index.
  localparam int NR = 14;

  // Round-key stage controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_OUT  = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8), reducing by 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add over the bits of b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumn.sv
// InvMixColumns on a single 32-bit column; byte 0 (bits [7:0]) is row 0.
module aes_inv_mixcolumn
  import aes_dec_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = col_i[7:0];
  assign b1 = col_i[15:8];
  assign b2 = col_i[23:16];
  assign b3 = col_i[31:24];

  // Circulant matrix {0e,0b,0d,09} applied to the column.
  always_comb begin
    col_o[7:0]   = gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09);
    col_o[15:8]  = gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d);
    col_o[23:16] = gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b);
    col_o[31:24] = gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e);
  end

endmodule

// File: rtl/aes_dec_addkey_invmix.sv
// Decryption round-key stage: fetches the round key, XORs it into the state and,
// for middle rounds, applies InvMixColumns.
// Build option: define AES_DEC_INVMIX_EN to include InvMixColumns for rounds 1..NR-1;
// left undefined the stage is a pure AddRoundKey and a later stage does InvMix.
module aes_dec_addkey_invmix
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [3:0]   in_round,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_ack,
  input  logic [127:0] key_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_err
);

  fsm_t   fsm_q, fsm_d;
  state_t data_q, data_d;
  round_t round_q, round_d;
  logic   err_q, err_d;

  logic [127:0] keyed;
  logic [127:0] result;

  assign keyed = data_q ^ key_data;

`ifdef AES_DEC_INVMIX_EN
  logic [127:0] mixed;
  logic         use_mix;

  assign use_mix = (round_q != 4'd0) && (round_q < round_t'(NR));

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_inv_mixcolumn u_col (
      .col_i (keyed[32*c +: 32]),
      .col_o (mixed[32*c +: 32])
    );
  end

  assign result = use_mix ? mixed : keyed;
`else
  assign result = keyed;
`endif

  // State, latched block and status registers; reset drops any pending request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= ST_IDLE;
      data_q  <= '0;
      round_q <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      round_q <= round_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept in IDLE, wait for the key in KEY, hold the result in OUT.
  always_comb begin
    fsm_d   = fsm_q;
    data_d  = data_q;
    round_d = round_q;
    err_d   = err_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_state;
          round_d = in_round;
          err_d   = (in_round > round_t'(NR));
          fsm_d   = (in_round > round_t'(NR)) ? ST_OUT : ST_KEY;
        end
      end
      ST_KEY: begin
        if (key_ack) begin
          data_d = result;
          fsm_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state; in_ready stays low while in reset.
  always_comb begin
    in_ready  = resetn && (fsm_q == ST_IDLE);
    key_req   = (fsm_q == ST_KEY);
    out_valid = (fsm_q == ST_OUT);
  end

  assign key_idx   = round_q;
  assign out_state = data_q;
  assign out_round = round_q;
  assign out_err   = err_q;

endmodule
